// File: rtl/aes_key_sched_ctrl_128.sv
// AES-128 key schedule controller: launches the shared expander, captures round keys 0..10,
// and serves them to the encrypt/decrypt cores through one round-robin arbitrated read port.
module aes_key_sched_ctrl_128 #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [127:0]          key_in,
    input  logic                  key_valid,
    output logic                  key_ready,
    output logic                  exp_start,
    output logic [127:0]          exp_key,
    input  logic [127:0]          exp_subkey,
    input  logic [3:0]            exp_cnt,
    input  logic                  exp_valid,
    output logic                  keys_ready,
    output logic [NUM_ROUNDS:0]   avail,
    input  logic                  r0_req,
    input  logic [3:0]            r0_idx,
    input  logic                  r1_req,
    input  logic [3:0]            r1_idx,
    output logic                  r0_gnt,
    output logic                  r1_gnt,
    output logic                  rvalid,
    output logic                  rsel,
    output logic [127:0]          rkey,
    output logic                  rerr
);

    localparam int unsigned KEY_W    = 128;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned IDX_SPAN = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               wr_sub;
    logic               sub_ok;
    logic               ptr_q;
    logic               r0_elig;
    logic               r1_elig;
    logic               contended;
    logic               gnt_any;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_err;
    logic [KEY_W-1:0]   rd_data;
    logic [IDX_SPAN-1:0] avail_x;
    logic [KEY_W-1:0]   store [0:NUM_ROUNDS];

    assign sub_ok = exp_valid && (exp_cnt != '0) && (exp_cnt <= IDX_W'(NUM_ROUNDS));

    // Next-state: accept a key whenever not expanding, finish on the last round key
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wr_sub  = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (sub_ok) begin
                    wr_sub = 1'b1;
                    if (exp_cnt == IDX_W'(NUM_ROUNDS)) begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range indices are always eligible so they can be answered with an error
    assign avail_x   = IDX_SPAN'(avail);
    assign r0_elig   = r0_req && ((r0_idx > IDX_W'(NUM_ROUNDS)) || avail_x[r0_idx]);
    assign r1_elig   = r1_req && ((r1_idx > IDX_W'(NUM_ROUNDS)) || avail_x[r1_idx]);
    assign contended = r0_elig && r1_elig;

    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (reset) begin
            if (contended) begin
                r0_gnt = ~ptr_q;
                r1_gnt = ptr_q;
            end else begin
                r0_gnt = r0_elig;
                r1_gnt = r1_elig;
            end
        end
    end

    assign gnt_any = r0_gnt | r1_gnt;
    assign rd_idx  = r1_gnt ? r1_idx : r0_idx;
    assign rd_err  = rd_idx > IDX_W'(NUM_ROUNDS);

    // Slot 0 is being overwritten this edge on accept; forward the incoming key
    always_comb begin
        rd_data = '0;
        if (!rd_err) begin
            if (accept && (rd_idx == '0)) begin
                rd_data = key_in;
            end else begin
                rd_data = store[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            key_ready  <= 1'b1;
            exp_start  <= 1'b0;
            exp_key    <= '0;
            keys_ready <= 1'b0;
            avail      <= '0;
            ptr_q      <= 1'b0;
            rvalid     <= 1'b0;
            rsel       <= 1'b0;
            rkey       <= '0;
            rerr       <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_ready <= (state_d != ST_EXPAND);
            exp_start <= accept;
            if (accept) begin
                exp_key    <= key_in;
                avail      <= {{NUM_ROUNDS{1'b0}}, 1'b1};
                keys_ready <= 1'b0;
            end else if (wr_sub) begin
                avail[exp_cnt] <= 1'b1;
                if (exp_cnt == IDX_W'(NUM_ROUNDS)) begin
                    keys_ready <= 1'b1;
                end
            end
            if (contended) begin
                ptr_q <= ~ptr_q;
            end
            rvalid <= gnt_any;
            if (gnt_any) begin
                rsel <= r1_gnt;
                rkey <= rd_data;
                rerr <= rd_err;
            end
        end
    end

    // Round-key storage; contents are masked by avail so no reset is needed
    always_ff @(posedge clk) begin
        if (reset) begin
            if (accept) begin
                store[0] <= key_in;
            end else if (wr_sub) begin
                store[exp_cnt] <= exp_subkey;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl_128.sv
// Bench for aes_key_sched_ctrl_128: expander stand-in driven from a round-key table,
// read responses checked through a scoreboard queue.
module tb_aes_key_sched_ctrl_128;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct packed {
        logic         sel;
        logic         err;
        logic [127:0] key;
    } rd_t;

    logic         clk;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         exp_start;
    logic [127:0] exp_key;
    logic [127:0] exp_subkey;
    logic [3:0]   exp_cnt;
    logic         exp_valid;
    logic         keys_ready;
    logic [10:0]  avail;
    logic         r0_req;
    logic [3:0]   r0_idx;
    logic         r1_req;
    logic [3:0]   r1_idx;
    logic         r0_gnt;
    logic         r1_gnt;
    logic         rvalid;
    logic         rsel;
    logic [127:0] rkey;
    logic         rerr;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  key_set = 0;
    int  ectr    = 0;
    rd_t sb_q[$];

    aes_key_sched_ctrl_128 dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .exp_start  (exp_start),
        .exp_key    (exp_key),
        .exp_subkey (exp_subkey),
        .exp_cnt    (exp_cnt),
        .exp_valid  (exp_valid),
        .keys_ready (keys_ready),
        .avail      (avail),
        .r0_req     (r0_req),
        .r0_idx     (r0_idx),
        .r1_req     (r1_req),
        .r1_idx     (r1_idx),
        .r0_gnt     (r0_gnt),
        .r1_gnt     (r1_gnt),
        .rvalid     (rvalid),
        .rsel       (rsel),
        .rkey       (rkey),
        .rerr       (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set 0: FIPS-197 A.1 expansion; set 1: arbitrary distinct pattern for a second key
    function automatic logic [127:0] subkey(input int set, input int k);
        if (set == 0) begin
            case (k)
                0:  return FIPS_KEY;
                1:  return 128'ha0fafe1788542cb123a339392a6c7605;
                2:  return 128'hf2c295f27a96b9435935807a7359f67f;
                3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
                4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
                5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
                6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
                7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
                8:  return 128'head27321b58dbad2312bf5607f8d292f;
                9:  return 128'hac7766f319fadc2128d12941575c006e;
                10: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
                default: return '0;
            endcase
        end
        if (k == 0) return ALT_KEY;
        return {32'(k), 32'hA5A50000 + 32'(k), ~32'(k), 32'h12345678};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic sel, input logic [127:0] key, input logic err);
        rd_t it;
        it.sel = sel;
        it.err = err;
        it.key = key;
        sb_q.push_back(it);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_key_ready", 128'(key_ready), 128'(1));
        chk("rst_exp_start", 128'(exp_start), 128'(0));
        chk("rst_exp_key", exp_key, '0);
        chk("rst_keys_ready", 128'(keys_ready), 128'(0));
        chk("rst_avail", 128'(avail), 128'(0));
        chk("rst_gnt", 128'({r0_gnt, r1_gnt}), 128'(0));
        chk("rst_read", 128'({rvalid, rsel, rerr}), 128'(0));
        chk("rst_rkey", rkey, '0);
    endtask

    // Single read by one requester; called mid-cycle, returns mid-cycle after the grant edge
    task automatic rd(input int who, input int idx, input logic [127:0] key, input logic err);
        if (who == 0) begin
            r0_req = 1'b1;
            r0_idx = 4'(idx);
        end else begin
            r1_req = 1'b1;
            r1_idx = 4'(idx);
        end
        settle();
        chk("rd_gnt", 128'({r1_gnt, r0_gnt}), (who == 0) ? 128'(1) : 128'(2));
        push(who[0], key, err);
        tick();
        r0_req = 1'b0;
        r1_req = 1'b0;
        settle();
    endtask

    // Expander stand-in: starts on exp_start, emits one junk count-0 sample, then rounds 1..10
    initial begin
        exp_valid  = 1'b0;
        exp_cnt    = '0;
        exp_subkey = '0;
        forever begin
            @(negedge clk);
            exp_valid  = 1'b0;
            exp_cnt    = '0;
            exp_subkey = '0;
            if (!reset) begin
                ectr = 0;
            end else begin
                if (ectr != 0) begin
                    exp_valid  = 1'b1;
                    exp_cnt    = 4'(ectr);
                    exp_subkey = subkey(key_set, ectr);
                    ectr       = (ectr == 10) ? 0 : ectr + 1;
                end
                if (exp_start) begin
                    ectr       = 1;
                    exp_valid  = 1'b1;
                    exp_cnt    = '0;
                    exp_subkey = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
                end
            end
        end
    end

    // Monitor: every rvalid cycle must match the oldest expected read
    initial begin
        rd_t it;
        forever begin
            @(negedge clk);
            if (rvalid) begin
                if (sb_q.size() == 0) begin
                    chk("rd_unexpected", 128'(rvalid), 128'(0));
                end else begin
                    it = sb_q.pop_front();
                    chk("rd_sel", 128'(rsel), 128'(it.sel));
                    chk("rd_err", 128'(rerr), 128'(it.err));
                    chk("rd_key", rkey, it.key);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        r0_req    = 1'b0;
        r0_idx    = '0;
        r1_req    = 1'b0;
        r1_idx    = '0;
        tick();
        tick();
        settle();
        chk_reset_outputs();
        reset = 1'b1;

        // FIPS key load; r1 waits on round 10 from the cycle after the accept
        key_set   = 0;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        key_in    = '0;
        r1_req    = 1'b1;
        r1_idx    = 4'd10;
        settle();
        chk("e0_exp_start", 128'(exp_start), 128'(1));
        chk("e0_key_ready", 128'(key_ready), 128'(0));
        chk("e0_avail", 128'(avail), 128'(1));
        chk("e0_exp_key", exp_key, FIPS_KEY);
        chk("e0_r1_stall", 128'(r1_gnt), 128'(0));
        for (int j = 1; j <= 11; j++) begin
            tick();
            settle();
            if (j == 1) chk("exp_start_width", 128'(exp_start), 128'(0));
            chk("avail_grow", 128'(avail), 128'((1 << j) - 1));
            chk("keys_ready_time", 128'(keys_ready), 128'(j == 11));
            chk("key_ready_time", 128'(key_ready), 128'(j == 11));
            chk("r1_stall", 128'(r1_gnt), 128'(j == 11));
        end
        push(1'b1, subkey(0, 10), 1'b0);
        tick();
        r1_req = 1'b0;
        settle();

        rd(0, 1, subkey(0, 1), 1'b0);
        rd(1, 0, FIPS_KEY, 1'b0);

        // Contended stream: grants alternate starting with r0, full throughput
        r0_req = 1'b1;
        r1_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            r0_idx = 4'(c);
            r1_idx = 4'(10 - c);
            settle();
            if (c > 0) chk("rvalid_stream", 128'(rvalid), 128'(1));
            chk("rr_r0", 128'(r0_gnt), 128'(c % 2 == 0));
            chk("rr_r1", 128'(r1_gnt), 128'(c % 2 == 1));
            if (c % 2 == 0) push(1'b0, subkey(0, c), 1'b0);
            else            push(1'b1, subkey(0, 10 - c), 1'b0);
            tick();
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        settle();

        rd(0, 12, '0, 1'b1);

        // New key accepted in the same edge as a read of round 5: old round 5 returned
        key_set   = 1;
        key_in    = ALT_KEY;
        key_valid = 1'b1;
        r0_req    = 1'b1;
        r0_idx    = 4'd5;
        settle();
        chk("acc_rd_gnt", 128'(r0_gnt), 128'(1));
        push(1'b0, subkey(0, 5), 1'b0);
        tick();
        key_valid = 1'b0;
        r0_req    = 1'b0;
        settle();
        chk("acc_rd_avail", 128'(avail), 128'(1));
        chk("acc_rd_keys_ready", 128'(keys_ready), 128'(0));

        // Reset during the 5th EXPAND cycle
        for (int j = 1; j <= 4; j++) tick();
        settle();
        chk("mid_avail", 128'(avail), 128'(16'h000f));
        reset = 1'b0;
        tick();
        settle();
        chk_reset_outputs();
        reset = 1'b1;

        // Fresh load after reset
        key_in    = ALT_KEY;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        settle();
        chk("re_exp_key", exp_key, ALT_KEY);
        for (int j = 1; j <= 11; j++) tick();
        settle();
        chk("re_keys_ready", 128'(keys_ready), 128'(1));
        chk("re_avail", 128'(avail), 128'(16'h07ff));
        rd(1, 7, subkey(1, 7), 1'b0);
        rd(0, 0, ALT_KEY, 1'b0);

        // Reload in READY with a same-edge read of round 0: new key forwarded
        key_set   = 0;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        r0_req    = 1'b1;
        r0_idx    = 4'd0;
        settle();
        chk("fwd_gnt", 128'(r0_gnt), 128'(1));
        push(1'b0, FIPS_KEY, 1'b0);
        tick();
        key_valid = 1'b0;
        r0_req    = 1'b0;
        for (int j = 1; j <= 11; j++) tick();
        settle();
        rd(0, 10, subkey(0, 10), 1'b0);
        tick();
        tick();
        chk("sb_drain", 128'(sb_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl_128.md
# aes_key_sched_ctrl_128

Controller and round-key store for the AES-128 key expansion datapath. It accepts a 128-bit cipher key over a valid/ready handshake and pulses the expander's start input. It captures the eleven round keys (0..10) into an internal store as the expander produces them. It then serves round-key reads to two cipher cores, encrypt and decrypt, through a round-robin arbitrated single read port, so one expander instance is shared by both directions.

## Interface
- NUM_ROUNDS, 10: number of expanded round keys. Fixed for AES-128; the block is not required to work with other values.
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- key_in  input  128  cipher key (round 0), big-endian word order {w0,w1,w2,w3}
- key_valid  input  1  key_in valid
- key_ready  output  1  block can accept a key; high in IDLE and READY, low in EXPAND
- exp_start  output  1  one-cycle start pulse to expander
- exp_key  output  128  key driven to expander short_key; registered copy of the accepted key
- exp_subkey  input  128  expander subkey output
- exp_cnt  input  4  expander round counter
- exp_valid  input  1  expander valid_skey
- keys_ready  output  1  all 11 round keys stored
- avail  output  11  per-round "stored" flags, bit k = round k
- r0_req / r1_req  input  1  read request from encrypt / decrypt core
- r0_idx / r1_idx  input  4  requested round index
- r0_gnt / r1_gnt  output  1  combinational grant, same cycle as request
- rvalid  output  1  read data valid, one cycle after a grant
- rsel  output  1  requester the data belongs to (0/1), valid with rvalid
- rkey  output  128  round key, valid with rvalid
- rerr  output  1  index > 10 was granted; rkey = 0, valid with rvalid

## Operation
- States: IDLE (no key), EXPAND, READY. Reset enters IDLE.
- IDLE/READY: if key_valid && key_ready at edge E0:
  - store round 0 = key_in and set exp_key = key_in;
  - clear avail[10:1], set avail[0];
  - clear keys_ready;
  - go to EXPAND.
- exp_start is high for exactly the cycle after E0. The expander samples it at E1.
- EXPAND: at each edge with exp_valid && 1 ≤ exp_cnt ≤ 10, write exp_subkey to slot exp_cnt and set avail[exp_cnt].
- When slot 10 is written, set keys_ready and go to READY. Samples with exp_cnt = 0 or > 10 are ignored.
- A new key in READY restarts the same sequence. Earlier round keys become unavailable at the accepting edge.
- Arbitration:
  - A request is eligible if its idx > 10, or if avail[idx] = 1.
  - At most one grant per cycle. Grants are mutually exclusive.
  - Only one eligible requester: it is granted.
  - Both eligible: the requester named by the priority pointer wins. The pointer then moves to the other requester.
  - Pointer resets to r0. It moves only on contended grants.
- A request whose round is not yet available is not granted. The requester holds req and idx stable until granted; the block stalls it, it is not dropped.
- Read: a grant at edge E registers store[idx] (or 0 with rerr = 1 for idx > 10) into rkey, along with rsel. rvalid is high for the cycle after E.
- Simultaneous key acceptance and grant at the same edge: the read returns the round key stored before the accept. It returns the new key only when idx = 0.

## Timing
- Reset values:
  - key_ready 1 (IDLE), exp_start 0, exp_key 0;
  - keys_ready 0, avail 0;
  - gnt 0, rvalid 0, rsel 0, rkey 0, rerr 0;
  - store contents don't-care, but masked by avail.
- Accept at E0:
  - round k (1..10) is written at edge E(k+1);
  - avail[k] is visible after E(k+1);
  - keys_ready and key_ready are high after E11;
  - the earliest next accept is E12.
- Read latency: 1 cycle from grant to rvalid. Back-to-back grants on consecutive cycles are supported (full throughput).
- Reset mid-EXPAND: the block returns to IDLE with avail = 0. The expander shares the reset domain; its reset polarity adaptation is done at top level.

## Test plan
- Load the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c. Required response:
  - exp_start is one cycle wide;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - keys_ready rises 11 edges after the accept.
- r1 requests idx 10 right after the accept. Required: r1_gnt stays low until avail[10] is set; rvalid follows the next cycle with round 10 and rsel = 1.
- r0 and r1 request continuously in READY. Required: grants alternate r0, r1, r0, …; rvalid is high every cycle; the rsel sequence matches.
- r0 requests idx 12. Required: granted; rvalid = 1, rerr = 1, rkey = 0.
- Accept a new key in READY in the same cycle as an r0 grant for idx 5. Required: the returned key is the old round 5; avail reads 0x001 next cycle.
- Assert reset low at the 5th cycle of EXPAND. Required: all outputs return to their reset values next cycle, and a fresh load completes normally.
